pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order integer pipeline. It generalises the fixed 5-stage load-use detector and two-source forwarding unit into one block. The block keeps a shift-register scoreboard of in-flight destination registers and per-instruction result latency. It sits between decode and the EX operand multiplexers, and drives stall, PC-write and registered forwarding selects for any depth or latency mix.

## Interface
- `NSTAGE`, default 3: scoreboard entries after decode (entry 0 = EX, 1 = MEM, NSTAGE-1 = WB); minimum 2.
- `RAW`, default 5: register address width.
- `LATW`, default 2: width of the latency field.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset. **One clock; reset is synchronous and active-high.**
- `id_valid` in 1: decode holds a real instruction.
- `id_rs`, `id_rt` in RAW: source registers of the decode instruction.
- `id_rd` in RAW: destination register of the decode instruction.
- `id_reg_write` in 1: decode instruction writes `id_rd`.
- `id_lat` in LATW: entry index from which the result can be forwarded (ALU = 1, load = 2).
- `flush` in 1: squash the decode instruction this cycle.
- `hold` in 1: external freeze of the whole pipeline.
- `stall` out 1: decode is blocked by a hazard (combinational).
- `pc_write` out 1: `~stall & ~hold`.
- `ex_valid` out 1: entry 0 holds a real instruction.
- `fwd_sel_a`, `fwd_sel_b` out $clog2(NSTAGE): operand source for the EX instruction. 0 = register file; k = result of entry k.

## Operation
- **Entry fields:** each entry holds {valid, rd, reg_write, lat}.
- **Match rule:** source s matches entry i when all hold:
  - entry valid;
  - entry reg_write;
  - entry rd == s;
  - s != 0.
  - Only i in 0..NSTAGE-2 is considered. Entry NSTAGE-1 writes back this cycle, and the write-through register file covers it.
- **Youngest wins:** the lowest matching i decides.
- **Hazard:** the youngest match for rs or rt has lat > i+1 (the result is not ready when the consumer reaches EX). Then `stall` = `id_valid & ~flush & hazard`.
- **Forward select:** at issue, `fwd_sel` = i+1 for the youngest match, else 0.
- **Advance (no hold):**
  - entries shift i → i+1; entry NSTAGE-1 is discarded;
  - entry 0 loads the decode instruction when `id_valid & ~flush & ~stall`, otherwise a bubble (valid = 0, reg_write = 0, fwd_sel = 0).
- **Hold:** all entries and `fwd_sel` are frozen; `stall` is still computed; `pc_write` = 0.
- **Priority:** rst > hold > flush > stall > issue.
- **Bubble:** a bubble entry never matches.

## Timing
- **Reset:**
  - all entries invalid;
  - `ex_valid` = 0, `fwd_sel_a` = `fwd_sel_b` = 0;
  - `stall` = 0, `pc_write` = 1 while rst is high.
  - Reset mid-operation drops all in-flight entries in one cycle.
- **Latency:**
  - `stall` and `pc_write` are same-cycle combinational from the id_* inputs and the entries.
  - `fwd_sel` and `ex_valid` are registered, valid one cycle after issue, aligned with the instruction in EX.
- **Load-use, default params:** a load (lat 2) in entry 0 with a dependent instruction in decode gives one stall cycle. Next cycle the load is in entry 1, 2 > 2 is false, and the consumer issues with `fwd_sel` = 2.
- **Stall length:** a producer with lat L at entry i stalls L-i-1 cycles.
- **Simultaneous matches:** both rs and rt matching different entries give independent selects. Stall if either operand is hazardous.
- **Flush and stall together:** flush wins; no stall, bubble issued.

## Structure
- **Package `pipe_pkg`:**
  - entry struct {valid, rd, reg_write, lat};
  - `FWD_RF` = 0 constant;
  - function computing the select width from NSTAGE.
- **Sub-module `hz_match`:**
  - per-source priority comparator over the entries;
  - outputs `hit`, `idx`, `not_ready`;
  - instantiated twice (rs, rt).

## Test plan
- **Back-to-back ALU:** `add r3` issued, then `sub r5,r3,r4` → no stall, `fwd_sel_a` = 1 when sub is in EX.
- **Load-use:** `lw r2` (lat 2), then `add r6,r2,r2` → `stall` = 1 for exactly 1 cycle, then `fwd_sel_a` = `fwd_sel_b` = 2.
- **Youngest wins:** `add r7` (lat 1), `add r7` (lat 1), `or r8,r7,r0` → `fwd_sel_a` = 1, `fwd_sel_b` = 0 (r0 never matches).
- **Deep latency:** NSTAGE = 5, producer lat 4, dependent instruction follows immediately → 3 stall cycles, then `fwd_sel` = 4.
- **Hold during load-use:** `hold` high for 2 cycles → entries frozen, `pc_write` = 0, then normal 1-cycle stall.
- **Flush and reset:** flush during a stall cycle → bubble, `stall` = 0; rst pulse with 3 valid entries → `ex_valid` = 0 and all `fwd_sel` = 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard / forwarding controller.
// Entry fields are sized for the widest supported configuration; narrower
// register-address and latency inputs are zero-extended into them.
package pipe_pkg;

   // Widest register address and latency field an entry can hold
   localparam int RAW_MAX = 8;
   localparam int LAT_MAX = 4;

   // Forward select value meaning "take the operand from the register file"
   localparam int FWD_RF = 0;

   // One in-flight instruction as seen by the scoreboard
   typedef struct packed {
      logic               valid;
      logic [RAW_MAX-1:0] rd;
      logic               reg_write;
      logic [LAT_MAX-1:0] lat;
   } entry_t;

   // Width of a forward select able to name entry results 1..nstage-1
   function automatic int sel_width(input int nstage);
      return (nstage < 2) ? 1 : $clog2(nstage);
   endfunction

endpackage

// File: rtl/hz_match.sv
// Per-source priority comparator: finds the youngest live scoreboard entry
// writing the given source register and reports whether its result is
// already forwardable when the consumer reaches EX.
module hz_match
   import pipe_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int SELW   = sel_width(NSTAGE)
) (
   input  logic [RAW_MAX-1:0] src,
   input  entry_t             entries [NSTAGE-1],
   output logic               hit,
   output logic [SELW-1:0]    idx,
   output logic               not_ready
);

   logic match_s;

   // Scan from oldest to youngest so the lowest matching index is the last one written
   always_comb begin
      hit       = 1'b0;
      idx       = '0;
      not_ready = 1'b0;
      match_s   = 1'b0;
      for (int i = NSTAGE - 2; i >= 0; i--) begin
         match_s = entries[i].valid && entries[i].reg_write &&
                   (entries[i].rd == src) && (src != '0);
         if (match_s) begin
            hit       = 1'b1;
            idx       = SELW'(i);
            not_ready = (int'(entries[i].lat) > (i + 1));
         end else begin
            hit       = hit;
            idx       = idx;
            not_ready = not_ready;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order integer pipeline.
// A shift-register scoreboard tracks destination registers and result
// latency of instructions between EX and WB. The WB slot is not stored:
// the write-through register file already covers it, so nothing here ever
// looks at it. Stall / PC-write are combinational; forward selects and
// ex_valid are registered and line up with the instruction in EX.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter  int NSTAGE = 3,
   parameter  int RAW    = 5,
   parameter  int LATW   = 2,
   localparam int SELW   = sel_width(NSTAGE)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RAW-1:0]  id_rs,
   input  logic [RAW-1:0]  id_rt,
   input  logic [RAW-1:0]  id_rd,
   input  logic            id_reg_write,
   input  logic [LATW-1:0] id_lat,
   input  logic            flush,
   input  logic            hold,
   output logic            stall,
   output logic            pc_write,
   output logic            ex_valid,
   output logic [SELW-1:0] fwd_sel_a,
   output logic [SELW-1:0] fwd_sel_b
);

   localparam int NLIVE = NSTAGE - 1;

   entry_t             entries_r [NLIVE];
   logic [SELW-1:0]    sel_a_r;
   logic [SELW-1:0]    sel_b_r;

   entry_t             id_entry_s;
   logic [RAW_MAX-1:0] rs_ext_s;
   logic [RAW_MAX-1:0] rt_ext_s;
   logic               hit_a_s;
   logic               hit_b_s;
   logic [SELW-1:0]    idx_a_s;
   logic [SELW-1:0]    idx_b_s;
   logic               nr_a_s;
   logic               nr_b_s;
   logic [SELW-1:0]    sel_a_s;
   logic [SELW-1:0]    sel_b_s;
   logic               hazard_s;
   logic               stall_s;
   logic               pc_write_s;
   logic               issue_s;

   // Widen decode fields into the scoreboard entry format
   always_comb begin
      id_entry_s           = '0;
      id_entry_s.valid     = 1'b1;
      id_entry_s.rd        = RAW_MAX'(id_rd);
      id_entry_s.reg_write = id_reg_write;
      id_entry_s.lat       = LAT_MAX'(id_lat);
      rs_ext_s             = RAW_MAX'(id_rs);
      rt_ext_s             = RAW_MAX'(id_rt);
   end

   hz_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_a (
      .src       (rs_ext_s),
      .entries   (entries_r),
      .hit       (hit_a_s),
      .idx       (idx_a_s),
      .not_ready (nr_a_s)
   );

   hz_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_b (
      .src       (rt_ext_s),
      .entries   (entries_r),
      .hit       (hit_b_s),
      .idx       (idx_b_s),
      .not_ready (nr_b_s)
   );

   // Forward selects name the matching entry's result (entry index + 1)
   always_comb begin
      if (hit_a_s) begin
         sel_a_s = idx_a_s + SELW'(1);
      end else begin
         sel_a_s = SELW'(FWD_RF);
      end
      if (hit_b_s) begin
         sel_b_s = idx_b_s + SELW'(1);
      end else begin
         sel_b_s = SELW'(FWD_RF);
      end
   end

   // Stall / PC-write decision; reset forces the pipeline-open values
   always_comb begin
      hazard_s = nr_a_s | nr_b_s;
      if (rst) begin
         stall_s    = 1'b0;
         pc_write_s = 1'b1;
      end else begin
         stall_s    = id_valid & ~flush & hazard_s;
         pc_write_s = ~stall_s & ~hold;
      end
      issue_s = id_valid & ~flush & ~stall_s;
   end

   assign stall     = stall_s;
   assign pc_write  = pc_write_s;
   assign ex_valid  = entries_r[0].valid;
   assign fwd_sel_a = sel_a_r;
   assign fwd_sel_b = sel_b_r;

   // Scoreboard shift with reset > hold > advance; entry 0 takes the issue or a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NLIVE; i++) begin
            entries_r[i] <= '0;
         end
         sel_a_r <= SELW'(FWD_RF);
         sel_b_r <= SELW'(FWD_RF);
      end else if (hold) begin
         for (int i = 0; i < NLIVE; i++) begin
            entries_r[i] <= entries_r[i];
         end
         sel_a_r <= sel_a_r;
         sel_b_r <= sel_b_r;
      end else begin
         for (int i = 1; i < NLIVE; i++) begin
            entries_r[i] <= entries_r[i-1];
         end
         if (issue_s) begin
            entries_r[0] <= id_entry_s;
            sel_a_r      <= sel_a_s;
            sel_b_r      <= sel_b_s;
         end else begin
            entries_r[0] <= '0;
            sel_a_r      <= SELW'(FWD_RF);
            sel_b_r      <= SELW'(FWD_RF);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default 3-stage, and a 5-stage
// with 3-bit latency) share one stimulus stream. A reference model tracks,
// per architectural register, the youngest in-flight writer and how many
// pipeline advances ago it issued; entry position, forwarding and hazards
// follow from that age.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic [2:0] id_lat;
   logic       flush;
   logic       hold;

   logic       stall3, pcw3, exv3;
   logic [1:0] fa3, fb3;
   logic       stall5, pcw5, exv5;
   logic [2:0] fa5, fb5;

   pipe_hazard_ctrl dut3 (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_lat       (id_lat[1:0]),
      .flush        (flush),
      .hold         (hold),
      .stall        (stall3),
      .pc_write     (pcw3),
      .ex_valid     (exv3),
      .fwd_sel_a    (fa3),
      .fwd_sel_b    (fb3)
   );

   pipe_hazard_ctrl #(.NSTAGE(5), .RAW(5), .LATW(3)) dut5 (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_lat       (id_lat),
      .flush        (flush),
      .hold         (hold),
      .stall        (stall5),
      .pc_write     (pcw5),
      .ex_valid     (exv5),
      .fwd_sel_a    (fa5),
      .fwd_sel_b    (fb5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state, index 0 = 3-stage instance, 1 = 5-stage instance
   int nst [2] = '{3, 5};
   int w_adv [2][32];
   int w_lat [2][32];
   bit w_ok  [2][32];
   int adv   [2];
   int e_exv [2];
   int e_sa  [2];
   int e_sb  [2];
   bit known = 1'b0;

   // Observed combinational outputs from the most recent cycle
   int obs_stall3, obs_stall5, obs_pcw3, obs_pcw5;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int mlat(int k);
      return (k == 0) ? int'(id_lat) % 4 : int'(id_lat);
   endfunction

   // Forward source for register s: age of youngest writer + 1 if still forwardable
   function automatic int msel(int k, int s);
      int age;
      if (s == 0 || !w_ok[k][s]) return 0;
      age = adv[k] - w_adv[k][s];
      if (age > nst[k] - 2) return 0;
      return age + 1;
   endfunction

   function automatic bit mhaz(int k, int s);
      int f;
      f = msel(k, s);
      return (f != 0) && (w_lat[k][s] > f);
   endfunction

   function automatic bit mstall(int k);
      return !rst && id_valid && !flush &&
             (mhaz(k, int'(id_rs)) || mhaz(k, int'(id_rt)));
   endfunction

   // One pipeline cycle: drive, check at negedge, advance model at posedge
   task automatic cyc(input bit r, input bit v, input int s1, input int s2,
                      input int d, input bit rw, input int l, input bit fl, input bit hd);
      bit st [2];
      int sa, sb;
      rst = r; id_valid = v; id_rs = 5'(s1); id_rt = 5'(s2); id_rd = 5'(d);
      id_reg_write = rw; id_lat = 3'(l); flush = fl; hold = hd;
      @(negedge clk);
      st[0] = mstall(0);
      st[1] = mstall(1);
      obs_stall3 = int'(stall3); obs_stall5 = int'(stall5);
      obs_pcw3   = int'(pcw3);   obs_pcw5   = int'(pcw5);
      chk("stall3", int'(stall3), int'(st[0]));
      chk("stall5", int'(stall5), int'(st[1]));
      chk("pc_write3", int'(pcw3), int'(r || (!st[0] && !hd)));
      chk("pc_write5", int'(pcw5), int'(r || (!st[1] && !hd)));
      if (known) begin
         chk("ex_valid3", int'(exv3), e_exv[0]);
         chk("fwd_a3", int'(fa3), e_sa[0]);
         chk("fwd_b3", int'(fb3), e_sb[0]);
         chk("ex_valid5", int'(exv5), e_exv[1]);
         chk("fwd_a5", int'(fa5), e_sa[1]);
         chk("fwd_b5", int'(fb5), e_sb[1]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            for (int g = 0; g < 32; g++) w_ok[k][g] = 1'b0;
            adv[k] = 0; e_exv[k] = 0; e_sa[k] = 0; e_sb[k] = 0;
         end else if (!hd) begin
            if (v && !fl && !st[k]) begin
               sa = msel(k, s1);
               sb = msel(k, s2);
               adv[k]++;
               e_exv[k] = 1; e_sa[k] = sa; e_sb[k] = sb;
               if (rw) begin
                  w_ok[k][d]  = 1'b1;
                  w_adv[k][d] = adv[k];
                  w_lat[k][d] = mlat(k);
               end
            end else begin
               adv[k]++;
               e_exv[k] = 0; e_sa[k] = 0; e_sb[k] = 0;
            end
         end
      end
      if (r) known = 1'b1;
      #1;
   endtask

   initial begin
      int cnt;
      rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
      id_reg_write = 1'b0; id_lat = '0; flush = 1'b0; hold = 1'b0;

      // Reset: stall low, pc_write high, then EX empty
      cyc(1, 1, 1, 2, 3, 1, 1, 0, 0);
      chk("rst_stall", obs_stall3, 0);
      chk("rst_pcw", obs_pcw3, 1);
      chk("rst_exv", int'(exv3), 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Back-to-back ALU: add r3 ; sub r5,r3,r4
      cyc(0, 1, 1, 2, 3, 1, 1, 0, 0);
      cyc(0, 1, 3, 4, 5, 1, 1, 0, 0);
      chk("b2b_stall", obs_stall3, 0);
      chk("b2b_fwd_a", int'(fa3), 1);
      chk("b2b_fwd_b", int'(fb3), 0);

      // Load-use: lw r2 ; add r6,r2,r2 -> one stall, then select 2 on both
      cyc(0, 1, 1, 0, 2, 1, 2, 0, 0);
      cyc(0, 1, 2, 2, 6, 1, 1, 0, 0);
      chk("lu_stall", obs_stall3, 1);
      chk("lu_pcw", obs_pcw3, 0);
      chk("lu_bubble", int'(exv3), 0);
      cyc(0, 1, 2, 2, 6, 1, 1, 0, 0);
      chk("lu_issue", obs_stall3, 0);
      chk("lu_fwd_a", int'(fa3), 2);
      chk("lu_fwd_b", int'(fb3), 2);

      // Youngest wins: add r7 ; add r7 ; or r8,r7,r0
      cyc(0, 1, 1, 1, 7, 1, 1, 0, 0);
      cyc(0, 1, 2, 2, 7, 1, 1, 0, 0);
      cyc(0, 1, 7, 0, 8, 1, 1, 0, 0);
      chk("yw_fwd_a", int'(fa3), 1);
      chk("yw_fwd_b", int'(fb3), 0);

      // Deep latency on the 5-stage instance: lat 4 -> three stalls, then select 4
      cyc(0, 1, 0, 0, 9, 1, 4, 0, 0);
      cnt = 0;
      for (int c = 0; c < 3; c++) begin
         cyc(0, 1, 9, 1, 10, 1, 1, 0, 0);
         cnt += obs_stall5;
      end
      chk("deep_stalls", cnt, 3);
      cyc(0, 1, 9, 1, 10, 1, 1, 0, 0);
      chk("deep_issue", obs_stall5, 0);
      chk("deep_fwd", int'(fa5), 4);

      // Hold during load-use: frozen twice, then a normal single stall
      cyc(0, 1, 0, 0, 10, 1, 2, 0, 0);
      cyc(0, 1, 10, 10, 11, 1, 1, 0, 1);
      chk("hold_stall", obs_stall3, 1);
      chk("hold_pcw", obs_pcw3, 0);
      cyc(0, 1, 10, 10, 11, 1, 1, 0, 1);
      chk("hold_pcw2", obs_pcw3, 0);
      cyc(0, 1, 10, 10, 11, 1, 1, 0, 0);
      chk("hold_after", obs_stall3, 1);
      cyc(0, 1, 10, 10, 11, 1, 1, 0, 0);
      chk("hold_issue", obs_stall3, 0);
      chk("hold_fwd", int'(fa3), 2);

      // Flush during a would-be stall: no stall, bubble in EX
      cyc(0, 1, 0, 0, 12, 1, 2, 0, 0);
      cyc(0, 1, 12, 0, 13, 1, 1, 1, 0);
      chk("flush_stall", obs_stall3, 0);
      chk("flush_pcw", obs_pcw3, 1);
      chk("flush_bubble", int'(exv3), 0);
      cyc(0, 1, 12, 0, 13, 1, 1, 0, 0);
      chk("flush_fwd", int'(fa3), 2);

      // Reset with a full scoreboard drops every in-flight writer
      cyc(0, 1, 0, 0, 13, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 14, 1, 3, 0, 0);
      cyc(0, 1, 0, 0, 15, 1, 3, 0, 0);
      cyc(1, 1, 15, 14, 16, 1, 1, 0, 0);
      chk("rst_mid_exv3", int'(exv3), 0);
      chk("rst_mid_fa3", int'(fa3), 0);
      chk("rst_mid_fb3", int'(fb3), 0);
      chk("rst_mid_exv5", int'(exv5), 0);
      cyc(0, 1, 15, 14, 16, 1, 1, 0, 0);
      chk("post_rst_stall", obs_stall3, 0);
      chk("post_rst_fa", int'(fa3), 0);
      chk("post_rst_fb", int'(fb3), 0);

      // Randomized traffic over a small register set to force frequent matches
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 8),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) < 8),
             int'($urandom_range(0, 4)),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
